ifetch_queue: RTL and testbench

- Consumer end of the program-counter interface: accepts fetch requests carrying the current PC, reads the synchronous instruction memory, and buffers the returned {PC, instruction} pairs in a small FIFO.
- Presents those pairs to the decode stage over a valid/ready handshake.
- Sits between the PC register and the decode stage.
- Supports a single-cycle flush on branch/jump redirect that discards all buffered and in-flight fetches.

---
 rtl/mips_pkg.sv | 12 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/ifetch_queue.sv | 75 +++++++
 tb/tb_ifetch_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths and the fetch-queue entry layout for the MIPS front end.
package mips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with a head-of-queue read port and a one-cycle clear.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch request acceptance, one-deep memory in-flight stage and decode-side queue.
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] REQ_PC,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              mem_en,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              flush,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic              inflight;
  logic [ADDR_W-1:0] pend_pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     credit;
  logic [EW-1:0]     head;
  logic              accept;
  logic              push;
  logic              pop;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; ready never looks at the partner's valid in the same cycle.
  assign credit    = count + CW'(inflight);
  assign req_ready = !flush && (credit < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign mem_en    = accept;
  assign MEM_ADDR  = REQ_PC;

  assign push        = inflight && !flush;
  assign instr_valid = (count != '0) && !flush;
  assign pop         = instr_valid && instr_ready;

  // accept is already blocked during flush, so the in-flight slot empties then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      pend_pc  <= '0;
    end else begin
      inflight <= accept;
      if (accept) pend_pc <= REQ_PC;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({pend_pc, MEM_RDATA}),
    .rdata (head),
    .count (count)
  );

  assign {INSTR_PC, INSTR} = head;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed table-driven bench for ifetch_queue with a behavioural instruction memory.
module tb_ifetch_queue;
  import mips_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] REQ_PC;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              mem_en;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              flush;
  logic [DATA_W-1:0] INSTR;
  logic [ADDR_W-1:0] INSTR_PC;
  logic              instr_valid;
  logic              instr_ready;

  ifetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .REQ_PC      (REQ_PC),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .MEM_ADDR    (MEM_ADDR),
    .mem_en      (mem_en),
    .MEM_RDATA   (MEM_RDATA),
    .flush       (flush),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  // ---------------- clock / memory model ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mword(input logic [31:0] pc);
    case (pc)
      32'h0:   return 32'h2008_0001;
      32'h4:   return 32'h2009_0002;
      32'h8:   return 32'h012A_5020;
      default: return 32'hA000_0000 | pc;
    endcase
  endfunction

  initial MEM_RDATA = '0;
  always @(posedge clk) if (mem_en) MEM_RDATA <= mword(MEM_ADDR);

  logic ovf_seen = 1'b0;
  always @(negedge clk)
    if (!rst && dut.push && dut.u_fifo.count == 3'(DEPTH)) ovf_seen <= 1'b1;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  bit          sb_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        ir;
    logic        fl;
    logic        rr;
    logic        me;
    logic        iv;
    logic        dchk;
    logic [31:0] hpc;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic rv, input logic [31:0] pc, input logic ir, input logic fl,
                              input logic rr, input logic me, input logic iv, input logic dchk,
                              input logic [31:0] hpc);
    vec_t v;
    v.rv = rv; v.pc = pc; v.ir = ir; v.fl = fl;
    v.rr = rr; v.me = me; v.iv = iv; v.dchk = dchk; v.hpc = hpc;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Entered 1 time unit after a rising edge; leaves at the same phase one cycle later.
  task automatic apply(input vec_t v, input string tag);
    logic [63:0] got;
    req_valid   = v.rv;
    REQ_PC      = v.pc;
    instr_ready = v.ir;
    flush       = v.fl;
    #2;
    check({tag, ".req_ready"}, 64'(req_ready), 64'(v.rr));
    check({tag, ".mem_en"}, 64'(mem_en), 64'(v.me));
    check({tag, ".instr_valid"}, 64'(instr_valid), 64'(v.iv));
    if (v.me) check({tag, ".mem_addr"}, 64'(MEM_ADDR), 64'(v.pc));
    if (v.dchk) begin
      check({tag, ".instr_pc"}, 64'(INSTR_PC), 64'(v.hpc));
      check({tag, ".instr"}, 64'(INSTR), 64'(mword(v.hpc)));
    end
    if (sb_on && instr_valid && instr_ready) begin
      got = {INSTR_PC, INSTR};
      if (exp_q.size() == 0) check({tag, ".sb_extra"}, got, 64'hDEAD);
      else check({tag, ".sb_order"}, got, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    foreach (tab[i]) apply(tab[i], $sformatf("%s[%0d]", tag, i));
    tab.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    fetch_entry_t e;
    rst = 1'b1; req_valid = 1'b0; REQ_PC = '0; flush = 1'b0; instr_ready = 1'b0;
    #2;
    check("rst.instr_valid", 64'(instr_valid), 64'd0);
    check("rst.mem_en", 64'(mem_en), 64'd0);
    check("rst.instr", 64'(INSTR), 64'd0);
    check("rst.instr_pc", 64'(INSTR_PC), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back stream, decode always ready
    tab.push_back(mk(0, 0,     1, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 0,     1, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 4,     1, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 8,     1, 0, 1, 1, 1, 1, 0));
    tab.push_back(mk(0, 0,     1, 0, 1, 0, 1, 1, 4));
    tab.push_back(mk(0, 0,     1, 0, 1, 0, 1, 1, 8));
    tab.push_back(mk(0, 0,     1, 0, 1, 0, 0, 0, 0));
    run_table("stream");

    // decode stalls: credit runs out after four accepts
    tab.push_back(mk(1, 'h10, 0, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 'h14, 0, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 'h18, 0, 0, 1, 1, 1, 1, 'h10));
    tab.push_back(mk(1, 'h1c, 0, 0, 1, 1, 1, 1, 'h10));
    tab.push_back(mk(1, 'h20, 0, 0, 0, 0, 1, 1, 'h10));
    tab.push_back(mk(1, 'h20, 0, 0, 0, 0, 1, 1, 'h10));
    tab.push_back(mk(1, 'h20, 1, 0, 0, 0, 1, 1, 'h10));
    tab.push_back(mk(1, 'h20, 0, 0, 1, 1, 1, 1, 'h14));
    tab.push_back(mk(1, 'h24, 0, 0, 0, 0, 1, 1, 'h14));
    tab.push_back(mk(0, 0,    1, 0, 0, 0, 1, 1, 'h14));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 1, 1, 'h18));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 1, 1, 'h1c));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 1, 1, 'h20));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 0, 0, 0));
    run_table("stall");

    // flush with three queued and one in flight, then a held flush
    tab.push_back(mk(1, 'h30, 0, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 'h34, 0, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 'h38, 0, 0, 1, 1, 1, 1, 'h30));
    tab.push_back(mk(1, 'h3c, 0, 0, 1, 1, 1, 1, 'h30));
    tab.push_back(mk(1, 'h50, 1, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 'h40, 1, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 1, 1, 'h40));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 'h60, 0, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 'h64, 0, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(1, 'h68, 1, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0,    1, 0, 1, 0, 0, 0, 0));
    run_table("flush");

    // steady push+pop at two queued entries; pointers wrap several times
    for (int i = 0; i < 13; i++) begin
      e.pc    = 32'h100 + 32'(4 * i);
      e.instr = mword(e.pc);
      exp_q.push_back(64'(e));
    end
    sb_on = 1'b1;
    tab.push_back(mk(1, 'h100, 0, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 'h104, 0, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 'h108, 0, 0, 1, 1, 1, 1, 'h100));
    for (int k = 0; k < 10; k++)
      tab.push_back(mk(1, 32'h10c + 32'(4 * k), 1, 0, 1, 1, 1, 1, 32'h100 + 32'(4 * k)));
    tab.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 'h128));
    tab.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 'h12c));
    tab.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 'h130));
    tab.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    run_table("steady");
    sb_on = 1'b0;
    check("steady.sb_left", 64'(exp_q.size()), 64'd0);

    // asynchronous reset between edges with data queued and in flight
    tab.push_back(mk(1, 'h80, 1, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(1, 'h84, 1, 0, 1, 1, 0, 0, 0));
    run_table("pre_arst");
    req_valid = 1'b0; instr_ready = 1'b0;
    #2;
    check("arst.before_valid", 64'(instr_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("arst.instr_valid", 64'(instr_valid), 64'd0);
    check("arst.instr", 64'(INSTR), 64'd0);
    check("arst.instr_pc", 64'(INSTR_PC), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    tab.push_back(mk(0, 0,     1, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(1, 'h200, 1, 0, 1, 1, 0, 0, 0));
    tab.push_back(mk(0, 0,     1, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 0,     1, 0, 1, 0, 1, 1, 'h200));
    tab.push_back(mk(0, 0,     1, 0, 1, 0, 0, 0, 0));
    run_table("post_arst");

    check("no_overflow", 64'(ovf_seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
